// File: rtl/demux3_stream.sv
// 1-to-3 valid/ready stream demultiplexer with one registered slot per output.
// The route is taken from in_select on a packet's first beat and held until its last beat.
module demux3_stream #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_last,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_last,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] c_data,
  output logic             c_last,
  output logic             c_valid,
  input  logic             c_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       route_reg, route_next;
  logic [1:0]       tgt;
  logic [2:0]       tgt_onehot;
  logic [2:0]       ready_vec;
  logic [2:0]       valid_vec;
  logic [2:0]       last_vec;
  logic [2:0]       load_vec;
  logic [WIDTH-1:0] data_vec [3];
  logic             accept;

  // The packet's first beat steers by in_select; later beats follow the locked route.
  assign tgt = (state_reg == IDLE) ? in_select : route_reg;

  always_comb begin
    tgt_onehot = 3'b000;
    case (tgt)
      2'b00:   tgt_onehot = 3'b001;
      2'b01:   tgt_onehot = 3'b010;
      default: tgt_onehot = 3'b100;
    endcase
  end

  assign ready_vec = {c_ready, b_ready, a_ready};
  assign in_ready  = |(tgt_onehot & (~valid_vec | ready_vec));
  assign accept    = in_valid & in_ready;
  assign load_vec  = tgt_onehot & {3{accept}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      route_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      route_reg <= route_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    route_next = route_reg;
    case (state_reg)
      IDLE: begin
        if (accept && !in_last) begin
          route_next = in_select;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && in_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      logic [WIDTH-1:0] data_reg;
      logic             last_reg;
      logic             valid_reg;

      // A load wins over a drain, so a same-cycle drain+load keeps the slot full.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg  <= '0;
          last_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end else if (load_vec[gi]) begin
          data_reg  <= in_data;
          last_reg  <= in_last;
          valid_reg <= 1'b1;
        end else if (valid_reg && ready_vec[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign data_vec[gi]  = data_reg;
      assign last_vec[gi]  = last_reg;
      assign valid_vec[gi] = valid_reg;
    end
  endgenerate

  assign a_data  = data_vec[0];
  assign a_last  = last_vec[0];
  assign a_valid = valid_vec[0];
  assign b_data  = data_vec[1];
  assign b_last  = last_vec[1];
  assign b_valid = valid_vec[1];
  assign c_data  = data_vec[2];
  assign c_last  = last_vec[2];
  assign c_valid = valid_vec[2];

endmodule
